// File: rtl/bp_update_ctrl.sv
// Branch-predictor counter update controller: in-order update FIFO feeding a
// read-modify-write pipeline into an external counter table. Define
// BP_UPD_BYPASS_EN to forward write-stage data on a same-index hazard
// instead of stalling the pop.
module bp_update_ctrl #(
   parameter int DEPTH  = 64,
   parameter int INDEX  = 6,
   parameter int WIDTH  = 2,
   parameter int QDEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             upd_valid_i,
   output logic             upd_ready_o,
   input  logic [INDEX-1:0] upd_index_i,
   input  logic             upd_taken_i,
   output logic [INDEX-1:0] rd_addr_o,
   input  logic [WIDTH-1:0] rd_data_i,
   output logic [INDEX-1:0] wr_addr_o,
   output logic [WIDTH-1:0] wr_data_o,
   output logic             we_o,
   output logic             busy_o
);

   localparam int QA = $clog2(QDEPTH);
   localparam logic [WIDTH-1:0] CMAX = '1;

   if (DEPTH > (1 << INDEX) || QDEPTH < 2 || (1 << QA) != QDEPTH) begin : g_param_check
      $error("bp_update_ctrl: DEPTH must fit INDEX bits, QDEPTH a power of 2 >= 2");
   end

   logic [INDEX:0]   q_mem [QDEPTH];   // {index, taken}
   logic [QA:0]      wr_ptr, rd_ptr;
   logic             full, empty, push, pop, hazard;
   logic [INDEX-1:0] head_idx;
   logic             head_tk;
   logic [WIDTH-1:0] old_val, nxt_val;
   logic             ws_valid;
   logic [INDEX-1:0] ws_idx;
   logic [WIDTH-1:0] ws_data;

   // Extra pointer bit distinguishes full from empty when the low bits match.
   assign full     = (wr_ptr[QA] != rd_ptr[QA]) && (wr_ptr[QA-1:0] == rd_ptr[QA-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign head_idx = q_mem[rd_ptr[QA-1:0]][INDEX:1];
   assign head_tk  = q_mem[rd_ptr[QA-1:0]][0];
   assign push     = upd_valid_i && upd_ready_o;
   assign hazard   = !empty && ws_valid && (head_idx == ws_idx);

`ifdef BP_UPD_BYPASS_EN
   assign pop     = !empty;
   assign old_val = hazard ? ws_data : rd_data_i;
`else
   // Stall one cycle so the pending write lands before the table is re-read.
   assign pop     = !empty && !hazard;
   assign old_val = rd_data_i;
`endif

   always_comb begin
      nxt_val = old_val;
      if (head_tk && old_val != CMAX)
         nxt_val = old_val + 1'b1;
      else if (!head_tk && old_val != '0)
         nxt_val = old_val - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push)
         q_mem[wr_ptr[QA-1:0]] <= {upd_index_i, upd_taken_i};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ws_valid <= 1'b0;
         ws_idx   <= '0;
         ws_data  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            ws_idx  <= head_idx;
            ws_data <= nxt_val;
         end
         ws_valid <= pop;
      end
   end

   // Outputs are forced to their idle values for the whole reset cycle,
   // including the cycle before the synchronous clear takes effect.
   assign upd_ready_o = !reset && !full;
   assign rd_addr_o   = (reset || empty) ? '0 : head_idx;
   assign wr_addr_o   = reset ? '0 : ws_idx;
   assign wr_data_o   = reset ? '0 : ws_data;
   assign we_o        = !reset && ws_valid;
   assign busy_o      = !reset && (!empty || ws_valid);

endmodule

// File: doc/bp_update_ctrl.md
BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of predictor counter entries.
REQ-002 SHALL have parameter INDEX, default 6: counter index width, log2(DEPTH).
REQ-003 SHALL have parameter WIDTH, default 2: saturating counter width.
REQ-004 SHALL have parameter QDEPTH, default 4: pending-update queue entries (power of 2).
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port upd_valid_i, input, 1: resolved-branch update offered.
REQ-008 SHALL have port upd_ready_o, output, 1: update accepted this cycle when high with upd_valid_i.
REQ-009 SHALL have port upd_index_i, input, INDEX: counter index to update.
REQ-010 SHALL have port upd_taken_i, input, 1: resolved outcome (1 = taken).
REQ-011 SHALL have port rd_addr_o, output, INDEX: counter-table read address; read data is combinational.
REQ-012 SHALL have port rd_data_i, input, WIDTH: counter value at rd_addr_o, same cycle.
REQ-013 SHALL have port wr_addr_o, output, INDEX: counter-table write address.
REQ-014 SHALL have port wr_data_o, output, WIDTH: counter-table write data.
REQ-015 SHALL have port we_o, output, 1: table write enable, sampled by the table on the next rising edge.
REQ-016 SHALL have port busy_o, output, 1: queue non-empty or write stage valid.

Function
REQ-017 SHALL buffer accepted updates in a FIFO of QDEPTH entries, in order.
REQ-018 SHALL drive upd_ready_o = queue not full, independent of a same-cycle pop.
REQ-019 SHALL not pop an entry in its push cycle; minimum push-to-pop latency is 1 cycle.
REQ-020 SHALL pop the head when the queue is non-empty and not stalled (REQ-027), driving rd_addr_o = head index.
REQ-021 SHALL compute next = old+1 if taken and old < 2^WIDTH-1; old-1 if not taken and old > 0; else old (saturate).
REQ-022 SHALL register {index, next} into a single write stage on the pop edge; we_o = 1 exactly one cycle later.
REQ-023 SHALL drive wr_addr_o, wr_data_o from the write-stage register; we_o = write-stage valid.
REQ-024 SHALL sustain one update per cycle with no same-index hazard; end-to-end latency push-to-we_o is 2 cycles minimum.
REQ-025 SHALL hold rd_addr_o at the head index (or 0 when empty) whenever no pop occurs.
REQ-026 SHALL treat a pop whose index equals the valid write-stage index as a same-index hazard.
REQ-027 SHALL resolve hazards per REQ-031/REQ-032; final table contents SHALL equal sequential in-order application of all updates.
REQ-028 SHALL derive full/empty from wrap-around pointers with one extra bit; simultaneous push and pop when neither full nor empty SHALL keep occupancy unchanged.

Reset
REQ-029 SHALL, while reset is high, empty the queue, clear write-stage valid, and drive upd_ready_o=0, we_o=0, busy_o=0, rd_addr_o=0, wr_addr_o=0, wr_data_o=0.
REQ-030 SHALL discard all pending and in-flight updates on reset mid-operation, with no write issued in the reset cycle or the cycle after.

Configuration
REQ-031 With BP_UPD_BYPASS_EN defined, on a same-index hazard the module SHALL use write-stage data instead of rd_data_i as old value, with no stall.
REQ-032 Without BP_UPD_BYPASS_EN, on a same-index hazard the module SHALL stall the pop one cycle (we_o completes first), then pop reading rd_data_i.

Verification
REQ-033 Reset, then push idx 5 taken with table[5]=2 -> we_o=1 two cycles after push, wr_addr_o=5, wr_data_o=3.
REQ-034 Table[9]=3: push idx 9 taken -> wr_data_o=3 (saturate high); table[9]=0, push not-taken -> wr_data_o=0.
REQ-035 Back-to-back pushes idx 7 taken x3, table[7]=0 -> writes 1,2,3; bypass build: consecutive we_o cycles; no-bypass build: one idle cycle between writes.
REQ-036 Hold upd_valid_i high, no pops possible (QDEPTH=4) -> exactly 4 accepted, upd_ready_o=0 until first pop; pointers wrap, order preserved over 12 updates.
REQ-037 Reset asserted with 3 queued updates -> no we_o afterward, busy_o=0 next cycle, upd_ready_o=1 after reset deasserts.
